// File: rtl/tl_a_rr_arbiter.sv
// tl_a_rr_arbiter: round-robin arbiter sharing one TileLink-UL A/D channel pair between N requesters,
// holding the grant across multi-beat Put bursts. Optional simulation monitor: define TL_A_ARB_MONITOR_EN.

module tl_a_rr_arbiter #(
   parameter int N = 2,
   parameter int IW = 4,
   localparam int SW = $clog2(N)
) (
   input  logic              clock,
   input  logic              reset,
   input  logic [N-1:0]      in_a_valid,
   output logic [N-1:0]      in_a_ready,
   input  logic [3*N-1:0]    in_a_opcode,
   input  logic [3*N-1:0]    in_a_param,
   input  logic [3*N-1:0]    in_a_size,
   input  logic [IW*N-1:0]   in_a_source,
   input  logic [26*N-1:0]   in_a_address,
   input  logic [4*N-1:0]    in_a_mask,
   input  logic [32*N-1:0]   in_a_data,
   output logic              out_a_valid,
   input  logic              out_a_ready,
   output logic [2:0]        out_a_opcode,
   output logic [2:0]        out_a_param,
   output logic [2:0]        out_a_size,
   output logic [IW+SW-1:0]  out_a_source,
   output logic [25:0]       out_a_address,
   output logic [3:0]        out_a_mask,
   output logic [31:0]       out_a_data,
   input  logic              out_d_valid,
   output logic              out_d_ready,
   input  logic [IW+SW-1:0]  out_d_source,
   output logic [N-1:0]      in_d_valid,
   input  logic [N-1:0]      in_d_ready,
   output logic [IW-1:0]     in_d_source
);

   typedef enum logic [0:0] {
      IDLE   = 1'b0,
      LOCKED = 1'b1
   } state_e;

   state_e          state_q;
   logic [SW-1:0]   rr_ptr_q;
   logic [SW-1:0]   lock_idx_q;
   logic [3:0]      beats_left_q;

   logic [SW-1:0]   grant_s;
   logic [SW-1:0]   cand_s;
   logic            found_s;
   logic            fire_s;
   logic [4:0]      beats_s;
   logic [SW-1:0]   tag_s;

   logic [2:0]      op_arr_s   [N];
   logic [2:0]      par_arr_s  [N];
   logic [2:0]      size_arr_s [N];
   logic [IW-1:0]   src_arr_s  [N];
   logic [25:0]     addr_arr_s [N];
   logic [3:0]      mask_arr_s [N];
   logic [31:0]     data_arr_s [N];

   // Beats in a burst: multi-beat only for PutFull/PutPartial wider than one 32-bit word.
   function automatic logic [4:0] burst_beats(input logic [2:0] opcode, input logic [2:0] size);
      logic [4:0] beats;
      beats = 5'd1;
      if ((opcode == 3'd0 || opcode == 3'd1) && size > 3'd2) begin
         case (size)
            3'd3:    beats = 5'd2;
            3'd4:    beats = 5'd4;
            3'd5:    beats = 5'd8;
            default: beats = 5'd16;
         endcase
      end else begin
         beats = 5'd1;
      end
      return beats;
   endfunction

   for (genvar i = 0; i < N; i++) begin : g_unpack
      assign op_arr_s[i]   = in_a_opcode[3*i +: 3];
      assign par_arr_s[i]  = in_a_param[3*i +: 3];
      assign size_arr_s[i] = in_a_size[3*i +: 3];
      assign src_arr_s[i]  = in_a_source[IW*i +: IW];
      assign addr_arr_s[i] = in_a_address[26*i +: 26];
      assign mask_arr_s[i] = in_a_mask[4*i +: 4];
      assign data_arr_s[i] = in_a_data[32*i +: 32];
   end

   // Grant selection: locked owner during a burst, otherwise first valid requester from rr_ptr.
   always_comb begin
      grant_s = rr_ptr_q;
      cand_s  = '0;
      found_s = 1'b0;
      if (state_q == LOCKED) begin
         grant_s = lock_idx_q;
      end else begin
         for (int k = 0; k < N; k++) begin
            cand_s = rr_ptr_q + SW'(k);
            if (!found_s && in_a_valid[cand_s]) begin
               grant_s = cand_s;
               found_s = 1'b1;
            end else begin
               found_s = found_s;
            end
         end
      end
   end

   // Zero-latency A mux and per-requester ready.
   always_comb begin
      out_a_valid   = 1'b0;
      out_a_opcode  = op_arr_s[grant_s];
      out_a_param   = par_arr_s[grant_s];
      out_a_size    = size_arr_s[grant_s];
      out_a_source  = {grant_s, src_arr_s[grant_s]};
      out_a_address = addr_arr_s[grant_s];
      out_a_mask    = mask_arr_s[grant_s];
      out_a_data    = data_arr_s[grant_s];
      if (!reset) begin
         out_a_valid = in_a_valid[grant_s];
      end else begin
         out_a_valid = 1'b0;
      end
      for (int i = 0; i < N; i++) begin
         in_a_ready[i] = out_a_ready & out_a_valid & (grant_s == SW'(i));
      end
   end

   assign fire_s  = out_a_valid & out_a_ready;
   assign beats_s = burst_beats(out_a_opcode, out_a_size);

   // Arbitration FSM: pointer advance, burst lock and beat countdown.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q      <= IDLE;
         rr_ptr_q     <= '0;
         lock_idx_q   <= '0;
         beats_left_q <= 4'd0;
      end else begin
         case (state_q)
            IDLE: begin
               if (fire_s) begin
                  if (beats_s == 5'd1) begin
                     rr_ptr_q <= grant_s + SW'(1);
                  end else begin
                     lock_idx_q   <= grant_s;
                     beats_left_q <= 4'(beats_s - 5'd1);
                     state_q      <= LOCKED;
                  end
               end
            end
            LOCKED: begin
               if (fire_s) begin
                  beats_left_q <= beats_left_q - 4'd1;
                  if (beats_left_q == 4'd1) begin
                     rr_ptr_q <= lock_idx_q + SW'(1);
                     state_q  <= IDLE;
                  end
               end
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign tag_s       = out_d_source[IW+SW-1:IW];
   assign in_d_source = out_d_source[IW-1:0];

   // D-channel return routing by the requester tag carried in the source.
   always_comb begin
      in_d_valid  = '0;
      out_d_ready = 1'b0;
      if (!reset) begin
         in_d_valid[tag_s] = out_d_valid;
         out_d_ready       = in_d_ready[tag_s];
      end else begin
         in_d_valid  = '0;
         out_d_ready = 1'b0;
      end
   end

`ifdef TL_A_ARB_MONITOR_EN
`ifndef SYNTHESIS
   localparam int FW = 3 + 3 + 3 + IW + SW + 26 + 4 + 32;

   logic            mon_stall_q;
   logic [SW-1:0]   mon_grant_q;
   logic [FW-1:0]   mon_fields_q;
   logic [6+IW+SW-1:0] mon_first_q;
   logic [FW-1:0]   mon_fields_s;
   logic [6+IW+SW-1:0] mon_first_s;

   assign mon_fields_s = {out_a_opcode, out_a_param, out_a_size, out_a_source,
                          out_a_address, out_a_mask, out_a_data};
   assign mon_first_s  = {out_a_opcode, out_a_size, out_a_source};

   // Protocol monitor: stall stability, burst header consistency, D tag range.
   always @(posedge clock) begin
      if (!reset) begin
         if (mon_stall_q && out_a_valid &&
             (grant_s != mon_grant_q || mon_fields_s != mon_fields_q)) begin
            $display("tl_a_rr_arbiter: A fields changed while stalled");
            $fatal(1, "tl_a_rr_arbiter: stall stability");
         end
         if (state_q == LOCKED && fire_s && mon_first_s != mon_first_q) begin
            $display("tl_a_rr_arbiter: burst beat header differs from first beat");
            $fatal(1, "tl_a_rr_arbiter: burst header");
         end
         if (out_d_valid && int'(tag_s) >= N) begin
            $display("tl_a_rr_arbiter: D tag out of range");
            $fatal(1, "tl_a_rr_arbiter: D tag");
         end
         mon_stall_q  <= out_a_valid & !out_a_ready;
         mon_grant_q  <= grant_s;
         mon_fields_q <= mon_fields_s;
         if (state_q == IDLE && fire_s) begin
            mon_first_q <= mon_first_s;
         end
      end else begin
         mon_stall_q <= 1'b0;
      end
   end
`endif
`else
   // Monitor compiled out in this build.
`endif

endmodule

// File: tb/tb_tl_a_rr_arbiter.sv
// Directed self-checking bench for tl_a_rr_arbiter (N=2 main instance, N=4 instance for D routing).
module tb_tl_a_rr_arbiter;

   logic clock = 1'b0;
   logic reset = 1'b1;
   always #5 clock = ~clock;

   int total = 0;
   int bad   = 0;

   logic [1:0]  in_a_valid = '0;
   logic [1:0]  in_a_ready;
   logic [5:0]  in_a_opcode = '0, in_a_param = '0, in_a_size = '0;
   logic [7:0]  in_a_source = '0;
   logic [51:0] in_a_address = '0;
   logic [7:0]  in_a_mask = '0;
   logic [63:0] in_a_data = '0;
   logic        out_a_valid;
   logic        out_a_ready = 1'b0;
   logic [2:0]  out_a_opcode, out_a_param, out_a_size;
   logic [4:0]  out_a_source;
   logic [25:0] out_a_address;
   logic [3:0]  out_a_mask;
   logic [31:0] out_a_data;
   logic        out_d_valid = 1'b0;
   logic        out_d_ready;
   logic [4:0]  out_d_source = '0;
   logic [1:0]  in_d_valid;
   logic [1:0]  in_d_ready = '0;
   logic [3:0]  in_d_source;

   tl_a_rr_arbiter #(.N(2), .IW(4)) dut (
      .clock(clock), .reset(reset),
      .in_a_valid(in_a_valid), .in_a_ready(in_a_ready),
      .in_a_opcode(in_a_opcode), .in_a_param(in_a_param), .in_a_size(in_a_size),
      .in_a_source(in_a_source), .in_a_address(in_a_address), .in_a_mask(in_a_mask),
      .in_a_data(in_a_data),
      .out_a_valid(out_a_valid), .out_a_ready(out_a_ready),
      .out_a_opcode(out_a_opcode), .out_a_param(out_a_param), .out_a_size(out_a_size),
      .out_a_source(out_a_source), .out_a_address(out_a_address), .out_a_mask(out_a_mask),
      .out_a_data(out_a_data),
      .out_d_valid(out_d_valid), .out_d_ready(out_d_ready), .out_d_source(out_d_source),
      .in_d_valid(in_d_valid), .in_d_ready(in_d_ready), .in_d_source(in_d_source)
   );

   logic [3:0]   a4_valid = '0;
   logic [3:0]   a4_ready;
   logic [11:0]  a4_op = '0, a4_par = '0, a4_size = '0;
   logic [15:0]  a4_src = '0;
   logic [103:0] a4_addr = '0;
   logic [15:0]  a4_mask = '0;
   logic [127:0] a4_data = '0;
   logic         o4_valid;
   logic [2:0]   o4_op, o4_par, o4_size;
   logic [5:0]   o4_src;
   logic [25:0]  o4_addr;
   logic [3:0]   o4_mask;
   logic [31:0]  o4_data;
   logic         d4_valid = 1'b0;
   logic         d4_ready_o;
   logic [5:0]   d4_source = '0;
   logic [3:0]   d4_in_valid;
   logic [3:0]   d4_in_ready = '0;
   logic [3:0]   d4_in_source;

   tl_a_rr_arbiter #(.N(4), .IW(4)) dut4 (
      .clock(clock), .reset(reset),
      .in_a_valid(a4_valid), .in_a_ready(a4_ready),
      .in_a_opcode(a4_op), .in_a_param(a4_par), .in_a_size(a4_size),
      .in_a_source(a4_src), .in_a_address(a4_addr), .in_a_mask(a4_mask),
      .in_a_data(a4_data),
      .out_a_valid(o4_valid), .out_a_ready(1'b0),
      .out_a_opcode(o4_op), .out_a_param(o4_par), .out_a_size(o4_size),
      .out_a_source(o4_src), .out_a_address(o4_addr), .out_a_mask(o4_mask),
      .out_a_data(o4_data),
      .out_d_valid(d4_valid), .out_d_ready(d4_ready_o), .out_d_source(d4_source),
      .in_d_valid(d4_in_valid), .in_d_ready(d4_in_ready), .in_d_source(d4_in_source)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic set_a(input int i, input logic v, input logic [2:0] op, input logic [2:0] sz,
                        input logic [3:0] src, input logic [31:0] data);
      in_a_valid[i]          = v;
      in_a_opcode[3*i +: 3]  = op;
      in_a_param[3*i +: 3]   = 3'd0;
      in_a_size[3*i +: 3]    = sz;
      in_a_source[4*i +: 4]  = src;
      in_a_address[26*i +: 26] = 26'(32'h100 * i);
      in_a_mask[4*i +: 4]    = 4'hF;
      in_a_data[32*i +: 32]  = data;
   endtask

   task automatic cyc();
      @(posedge clock);
      #1;
   endtask

   initial begin
      // Reset state with activity on every input
      set_a(0, 1'b1, 3'd4, 3'd2, 4'h5, 32'h0);
      set_a(1, 1'b1, 3'd4, 3'd2, 4'hA, 32'h0);
      out_a_ready = 1'b1;
      out_d_valid = 1'b1;
      out_d_source = 5'h10;
      in_d_ready = 2'b11;
      @(posedge clock);
      #1;
      chk("rst_out_a_valid", 64'(out_a_valid), 64'd0);
      chk("rst_in_a_ready", 64'(in_a_ready), 64'd0);
      chk("rst_in_d_valid", 64'(in_d_valid), 64'd0);
      chk("rst_out_d_ready", 64'(out_d_ready), 64'd0);
      chk("rst_state", 64'(dut.state_q), 64'd0);
      chk("rst_rr_ptr", 64'(dut.rr_ptr_q), 64'd0);
      chk("rst_beats_left", 64'(dut.beats_left_q), 64'd0);
      out_d_valid = 1'b0;
      reset = 1'b0;

      // Fairness: two single-beat Gets alternate
      for (int k = 0; k < 4; k++) begin
         #1;
         chk("fair_src", 64'(out_a_source), (k % 2 == 0) ? 64'h05 : 64'h1A);
         chk("fair_rdy", 64'(in_a_ready), (k % 2 == 0) ? 64'h1 : 64'h2);
         chk("fair_addr", 64'(out_a_address), (k % 2 == 0) ? 64'h0 : 64'h100);
         cyc();
      end
      chk("fair_rr_ptr", 64'(dut.rr_ptr_q), 64'd0);

      // Burst lock: 4-beat PutFull from req0 while req1 waits
      for (int k = 0; k < 4; k++) begin
         set_a(0, 1'b1, 3'd0, 3'd4, 4'h5, 32'hD000_0000 + 32'(k));
         #1;
         chk("lock_rdy", 64'(in_a_ready), 64'h1);
         chk("lock_data", 64'(out_a_data), 64'hD000_0000 + 64'(k));
         cyc();
         if (k == 0) chk("lock_state", 64'(dut.state_q), 64'd1);
      end
      chk("lock_release_state", 64'(dut.state_q), 64'd0);
      chk("lock_release_ptr", 64'(dut.rr_ptr_q), 64'd1);
      set_a(0, 1'b0, 3'd4, 3'd2, 4'h5, 32'h0);
      #1;
      chk("lock_req1_rdy", 64'(in_a_ready), 64'h2);
      cyc();
      chk("lock_req1_ptr", 64'(dut.rr_ptr_q), 64'd0);

      // Stalled 8-beat burst: owner drops valid after beat 2
      set_a(0, 1'b1, 3'd0, 3'd5, 4'h5, 32'h1111_0000);
      #1;
      chk("stall_b1_rdy", 64'(in_a_ready), 64'h1);
      cyc();
      chk("stall_b1_left", 64'(dut.beats_left_q), 64'd7);
      chk("stall_b2_rdy", 64'(in_a_ready), 64'h1);
      cyc();
      chk("stall_b2_left", 64'(dut.beats_left_q), 64'd6);
      in_a_valid[0] = 1'b0;
      for (int k = 0; k < 3; k++) begin
         #1;
         chk("stall_valid", 64'(out_a_valid), 64'd0);
         chk("stall_rdy", 64'(in_a_ready), 64'h0);
         cyc();
         chk("stall_left", 64'(dut.beats_left_q), 64'd6);
      end
      in_a_valid[0] = 1'b1;
      for (int k = 0; k < 6; k++) begin
         #1;
         chk("stall_resume_rdy", 64'(in_a_ready), 64'h1);
         cyc();
      end
      chk("stall_end_state", 64'(dut.state_q), 64'd0);
      chk("stall_end_ptr", 64'(dut.rr_ptr_q), 64'd1);
      in_a_valid[0] = 1'b0;
      #1;
      chk("stall_req1_rdy", 64'(in_a_ready), 64'h2);
      cyc();

      // Backpressure: pending Get with out_a_ready low
      in_a_valid[1] = 1'b0;
      set_a(0, 1'b1, 3'd4, 3'd2, 4'h5, 32'h0);
      out_a_ready = 1'b0;
      for (int k = 0; k < 5; k++) begin
         #1;
         chk("bp_valid", 64'(out_a_valid), 64'd1);
         chk("bp_rdy", 64'(in_a_ready), 64'h0);
         cyc();
         chk("bp_ptr", 64'(dut.rr_ptr_q), 64'd0);
      end
      out_a_ready = 1'b1;
      #1;
      chk("bp_fire_rdy", 64'(in_a_ready), 64'h1);
      cyc();
      chk("bp_fire_ptr", 64'(dut.rr_ptr_q), 64'd1);

      // Scan wraps from rr_ptr=1 back to requester 0
      out_a_ready = 1'b0;
      #1;
      chk("wrap_src", 64'(out_a_source), 64'h05);

      // D routing on N=2
      out_d_valid  = 1'b1;
      out_d_source = 5'h17;
      in_d_ready   = 2'b10;
      #1;
      chk("d2_valid", 64'(in_d_valid), 64'h2);
      chk("d2_source", 64'(in_d_source), 64'h7);
      chk("d2_ready_hi", 64'(out_d_ready), 64'd1);
      in_d_ready = 2'b01;
      #1;
      chk("d2_ready_lo", 64'(out_d_ready), 64'd0);

      // D routing on N=4
      d4_valid    = 1'b1;
      d4_source   = 6'b10_0011;
      d4_in_ready = 4'b0100;
      #1;
      chk("d4_valid", 64'(d4_in_valid), 64'h4);
      chk("d4_source", 64'(d4_in_source), 64'h3);
      chk("d4_ready_hi", 64'(d4_ready_o), 64'd1);
      d4_in_ready = 4'b1011;
      #1;
      chk("d4_ready_lo", 64'(d4_ready_o), 64'd0);
      d4_valid = 1'b0;
      #1;
      chk("d4_idle", 64'(d4_in_valid), 64'h0);

      // Reset mid-burst: req1 4-beat put, reset after beat 2
      in_a_valid[0] = 1'b0;
      set_a(1, 1'b1, 3'd0, 3'd4, 4'hA, 32'h2222_0000);
      out_a_ready = 1'b1;
      in_d_ready  = 2'b11;
      #1;
      chk("rmb_b1_rdy", 64'(in_a_ready), 64'h2);
      cyc();
      chk("rmb_b2_rdy", 64'(in_a_ready), 64'h2);
      cyc();
      chk("rmb_left", 64'(dut.beats_left_q), 64'd2);
      set_a(0, 1'b1, 3'd4, 3'd2, 4'h5, 32'h0);
      #1;
      chk("rmb_locked_rdy", 64'(in_a_ready), 64'h2);
      reset = 1'b1;
      #1;
      chk("rmb_out_a_valid", 64'(out_a_valid), 64'd0);
      chk("rmb_in_a_ready", 64'(in_a_ready), 64'h0);
      chk("rmb_in_d_valid", 64'(in_d_valid), 64'h0);
      chk("rmb_out_d_ready", 64'(out_d_ready), 64'd0);
      chk("rmb_state", 64'(dut.state_q), 64'd0);
      chk("rmb_ptr", 64'(dut.rr_ptr_q), 64'd0);
      cyc();
      reset = 1'b0;
      out_d_valid = 1'b0;
      set_a(1, 1'b1, 3'd4, 3'd2, 4'hA, 32'h0);
      #1;
      chk("rmb_after_rdy", 64'(in_a_ready), 64'h1);
      chk("rmb_after_src", 64'(out_a_source), 64'h05);
      cyc();

      // Get with large size stays single-beat; PutPartial size 7 clamps to 16 beats
      in_a_valid[0] = 1'b0;
      set_a(1, 1'b1, 3'd4, 3'd6, 4'hA, 32'h0);
      #1;
      chk("bigget_rdy", 64'(in_a_ready), 64'h2);
      cyc();
      chk("bigget_state", 64'(dut.state_q), 64'd0);
      chk("bigget_ptr", 64'(dut.rr_ptr_q), 64'd0);
      in_a_valid[1] = 1'b0;
      set_a(0, 1'b1, 3'd1, 3'd7, 4'h5, 32'h0);
      #1;
      chk("clamp_rdy", 64'(in_a_ready), 64'h1);
      cyc();
      chk("clamp_state", 64'(dut.state_q), 64'd1);
      chk("clamp_left", 64'(dut.beats_left_q), 64'd15);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
